sync_fifo_addr_gen: RTL and testbench
=====================================

Name: sync_fifo_addr_gen

Overview:
- Upstream pointer stage of the sync FIFO. Converts the write/read handshakes into the memory write/read enables and addresses.
- Produces the extended (wrap-bit) write and read pointers that the flag comparator consumes. The comparator returns its registered ready/valid status to this block.
- Also keeps a registered occupancy count, supports a synchronous flush, and can optionally flag overflow/underflow attempts.

Parameters:
- FIFO_DEPTH, 16 (default taken from the shared sync FIFO defines include), number of entries; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), memory address width; pointers are ADDR_WIDTH+1 bits wide.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- i_valid_s  in  1  source requests a write
- i_ready_m  in  1  sink requests a read
- i_flush  in  1  synchronous clear of pointers, count and error flags
- i_wr_ok  in  1  comparator o_ready_s (FIFO not full)
- i_rd_ok  in  1  comparator o_valid_m (FIFO not empty)
- o_wr_en  out  1  memory write strobe
- o_rd_en  out  1  memory read strobe
- wr_addr  out  ADDR_WIDTH+1  write pointer including wrap bit, to comparator
- rd_addr  out  ADDR_WIDTH+1  read pointer including wrap bit, to comparator
- o_mem_wr_addr  out  ADDR_WIDTH  wr_addr[ADDR_WIDTH-1:0]
- o_mem_rd_addr  out  ADDR_WIDTH  rd_addr[ADDR_WIDTH-1:0]
- o_count  out  ADDR_WIDTH+1  registered occupancy, range 0..FIFO_DEPTH
- o_overflow  out  1  sticky: write attempted while full (optional feature)
- o_underflow  out  1  sticky: read attempted while empty (optional feature)

Behaviour:
- Reset: wr_addr=0, rd_addr=0, o_count=0, o_overflow=0, o_underflow=0. o_wr_en and o_rd_en are combinational and therefore 0 while inputs are idle.
- Read enable (combinational, zero latency): o_rd_en = i_ready_m & i_rd_ok & ~i_flush & (o_count != 0).
- Write enable (combinational, zero latency): o_wr_en = i_valid_s & i_wr_ok & ~i_flush & ((o_count != FIFO_DEPTH) | o_rd_en).
  - The local count guards make the block safe even if the comparator status lags.
  - A simultaneous read and write at full is accepted.
- Pointer update: wr_addr increments by 1 on the clock edge after o_wr_en=1; rd_addr likewise on o_rd_en. Both wrap naturally modulo 2*FIFO_DEPTH, so the MSB toggles on each pass through the memory.
- o_count update: +1 on write only, -1 on read only, unchanged on both or neither. Invariant: o_count == wr_addr - rd_addr (mod 2*FIFO_DEPTH).
- Flush: i_flush=1 forces both strobes to 0; next edge sets pointers, count and error flags to 0. Flush has priority over all other events.
- Reset mid-operation: all state clears immediately (asynchronously); operation resumes at address 0 after reset_n deasserts.
- No FSM beyond the two pointer counters and the count register; each memory transaction has one-cycle latency from handshake to pointer advance.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- With the macro defined:
  - o_overflow sets when i_valid_s=1, o_wr_en=0 and i_flush=0.
  - o_underflow sets when i_ready_m=1, o_rd_en=0 and i_flush=0.
  - Both are sticky until flush or reset.
- Without the macro: both ports remain present and are tied to 0; no flag registers are synthesized.

Decomposition:
- Shared defines include: FIFO_DEPTH default and the SYNC_FIFO_ERR_FLAGS_EN switch. The ADDR_WIDTH derivation is shared with the comparator.
- Sub-module: sync_fifo_ptr_cnt, an (ADDR_WIDTH+1)-bit counter with inc and clr inputs and async reset_n. It is instantiated twice, once for the write pointer and once for the read pointer.

Test Plan (FIFO_DEPTH=16):
- Reset, then 16 writes with no reads -> wr_addr=16 (0x10), o_count=16, rd_addr=0. A 17th write with i_wr_ok=1 gives o_wr_en=0.
- Full FIFO, i_valid_s=i_ready_m=1 with both ok inputs high -> both strobes 1, o_count stays 16, both pointers advance by 1.
- Write then read 40 times in a row -> pointers wrap through 31 back to 0. o_mem_wr_addr follows the sequence 0..15,0..15,0..7; o_count alternates 1/0.
- Load 5 entries, assert i_flush with i_valid_s=1 -> o_wr_en=0; next cycle pointers=0, o_count=0.
- With SYNC_FIFO_ERR_FLAGS_EN: read request at count 0 -> o_underflow=1 and held. Write request at count 16 -> o_overflow=1. Flush clears both.
- Assert reset_n=0 mid-burst at count 7 -> all outputs 0 without waiting for a clock edge; first write after release goes to address 0.

Source files
------------

// File: rtl/sync_fifo_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_addr_gen_pkg
// Shared sync FIFO settings: the default depth and the pointer-width helper
// that both this address generator and the flag comparator use.
// Optional build switch used by the address generator: SYNC_FIFO_ERR_FLAGS_EN.
// -----------------------------------------------------------------------------
package sync_fifo_addr_gen_pkg;

   localparam int SYNC_FIFO_DEPTH_DEF = 16;

   // Pointer width: memory address bits plus one wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_addr_gen_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_addr_gen_if
// Handshake/status/address bundle between the FIFO control logic and the
// address generator.
//   slave  : address generator view (i_* in, o_*/addr out)
//   master : driver/observer view
// -----------------------------------------------------------------------------
interface sync_fifo_addr_gen_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  i_valid_s;
   logic                  i_ready_m;
   logic                  i_flush;
   logic                  i_wr_ok;
   logic                  i_rd_ok;
   logic                  o_wr_en;
   logic                  o_rd_en;
   logic [ADDR_WIDTH:0]   wr_addr;
   logic [ADDR_WIDTH:0]   rd_addr;
   logic [ADDR_WIDTH-1:0] o_mem_wr_addr;
   logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
   logic [ADDR_WIDTH:0]   o_count;
   logic                  o_overflow;
   logic                  o_underflow;

   modport slave (
      input  i_valid_s, i_ready_m, i_flush, i_wr_ok, i_rd_ok,
      output o_wr_en, o_rd_en, wr_addr, rd_addr, o_mem_wr_addr,
             o_mem_rd_addr, o_count, o_overflow, o_underflow
   );

   modport master (
      output i_valid_s, i_ready_m, i_flush, i_wr_ok, i_rd_ok,
      input  o_wr_en, o_rd_en, wr_addr, rd_addr, o_mem_wr_addr,
             o_mem_rd_addr, o_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/sync_fifo_ptr_cnt.sv
// -----------------------------------------------------------------------------
// sync_fifo_ptr_cnt
// Free-running wrap-around pointer counter (wraps modulo 2**WIDTH).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   i_inc    advance by one on the next edge
//   i_clr    synchronous clear, higher priority than i_inc
//   o_cnt    current pointer value
// -----------------------------------------------------------------------------
module sync_fifo_ptr_cnt #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/sync_fifo_addr_gen.sv
// -----------------------------------------------------------------------------
// sync_fifo_addr_gen
// Pointer stage of the sync FIFO: turns write/read handshakes into memory
// strobes and addresses, keeps wrap-bit pointers for the flag comparator and
// a registered occupancy count, and supports a synchronous flush.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags;
// without it o_overflow/o_underflow are tied to 0.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      sync_fifo_addr_gen_if.slave: i_valid_s, i_ready_m, i_flush,
//            i_wr_ok, i_rd_ok in; o_wr_en, o_rd_en, wr_addr, rd_addr,
//            o_mem_wr_addr, o_mem_rd_addr, o_count, o_overflow, o_underflow out
// -----------------------------------------------------------------------------
module sync_fifo_addr_gen
   import sync_fifo_addr_gen_pkg::*;
#(
   parameter int FIFO_DEPTH = SYNC_FIFO_DEPTH_DEF,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sync_fifo_addr_gen_if.slave  bus
);

   localparam int                PTR_W  = ptr_width(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  C_FULL = PTR_W'(FIFO_DEPTH);

   logic [PTR_W-1:0] r_count;
   logic [PTR_W-1:0] w_wr_ptr;
   logic [PTR_W-1:0] w_rd_ptr;
   logic             w_wr_en;
   logic             w_rd_en;

   // Local count guards keep the strobes safe even if comparator status lags.
   // A write at full is still allowed when a read frees a slot the same cycle.
   assign w_rd_en = bus.i_ready_m & bus.i_rd_ok & ~bus.i_flush & (r_count != '0);
   assign w_wr_en = bus.i_valid_s & bus.i_wr_ok & ~bus.i_flush &
                    ((r_count != C_FULL) | w_rd_en);

   sync_fifo_ptr_cnt #(.WIDTH(PTR_W)) u_wr_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_wr_en),
      .i_clr   (bus.i_flush),
      .o_cnt   (w_wr_ptr)
   );

   sync_fifo_ptr_cnt #(.WIDTH(PTR_W)) u_rd_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_rd_en),
      .i_clr   (bus.i_flush),
      .o_cnt   (w_rd_ptr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_count <= '0;
      else if (bus.i_flush)
         r_count <= '0;
      else begin
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky: any refused request (not masked by flush) latches until flush/reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.i_flush) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.i_valid_s && !w_wr_en)
            r_overflow <= 1'b1;
         if (bus.i_ready_m && !w_rd_en)
            r_underflow <= 1'b1;
      end
   end

   assign bus.o_overflow  = r_overflow;
   assign bus.o_underflow = r_underflow;
`else
   assign bus.o_overflow  = 1'b0;
   assign bus.o_underflow = 1'b0;
`endif

   assign bus.o_wr_en       = w_wr_en;
   assign bus.o_rd_en       = w_rd_en;
   assign bus.wr_addr       = w_wr_ptr;
   assign bus.rd_addr       = w_rd_ptr;
   assign bus.o_mem_wr_addr = w_wr_ptr[ADDR_WIDTH-1:0];
   assign bus.o_mem_rd_addr = w_rd_ptr[ADDR_WIDTH-1:0];
   assign bus.o_count       = r_count;

endmodule

// File: tb/tb_sync_fifo_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_addr_gen
// Directed bench for sync_fifo_addr_gen at FIFO_DEPTH=16. A reference model
// predicts the strobes for each driven cycle and pushes the expected
// post-edge state into a queue that is popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_addr_gen;

   localparam int FIFO_DEPTH = 16;
   localparam int ADDR_WIDTH = 4;

   typedef struct {
      logic [ADDR_WIDTH:0] wr;
      logic [ADDR_WIDTH:0] rd;
      logic [ADDR_WIDTH:0] cnt;
      logic                ovf;
      logic                unf;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   exp_t q[$];

   logic [ADDR_WIDTH:0] m_wr, m_rd, m_cnt;
   logic                m_ovf, m_unf;

   sync_fifo_addr_gen_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

   sync_fifo_addr_gen #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic fl,
                        input logic wok, input logic rok);
      bus.i_valid_s = v;
      bus.i_ready_m = r;
      bus.i_flush   = fl;
      bus.i_wr_ok   = wok;
      bus.i_rd_ok   = rok;
   endtask

   task automatic model_reset();
      m_wr  = '0;
      m_rd  = '0;
      m_cnt = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One clock cycle: drive, check strobes mid-cycle, predict and push the
   // next state, then pop and compare after the edge.
   task automatic step(input logic v, input logic r, input logic fl,
                       input logic wok, input logic rok);
      logic exp_we, exp_re;
      exp_t e, got;
      drive(v, r, fl, wok, rok);
      #2;
      exp_re = r & rok & ~fl & (m_cnt != 0);
      exp_we = v & wok & ~fl & ((m_cnt != FIFO_DEPTH) | exp_re);
      chk("rd_en", 32'(bus.o_rd_en), 32'(exp_re));
      chk("wr_en", 32'(bus.o_wr_en), 32'(exp_we));
      if (fl) begin
         model_reset();
      end else begin
         if (exp_we) m_wr = m_wr + 1'b1;
         if (exp_re) m_rd = m_rd + 1'b1;
         if (exp_we && !exp_re) m_cnt = m_cnt + 1'b1;
         if (exp_re && !exp_we) m_cnt = m_cnt - 1'b1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         if (v && !exp_we) m_ovf = 1'b1;
         if (r && !exp_re) m_unf = 1'b1;
`endif
      end
      e.wr = m_wr; e.rd = m_rd; e.cnt = m_cnt; e.ovf = m_ovf; e.unf = m_unf;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         got = q.pop_front();
         chk("wr_addr",     32'(bus.wr_addr),       32'(got.wr));
         chk("rd_addr",     32'(bus.rd_addr),       32'(got.rd));
         chk("count",       32'(bus.o_count),       32'(got.cnt));
         chk("mem_wr_addr", 32'(bus.o_mem_wr_addr), 32'(got.wr[ADDR_WIDTH-1:0]));
         chk("mem_rd_addr", 32'(bus.o_mem_rd_addr), 32'(got.rd[ADDR_WIDTH-1:0]));
         chk("overflow",    32'(bus.o_overflow),    32'(got.ovf));
         chk("underflow",   32'(bus.o_underflow),   32'(got.unf));
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      model_reset();
      drive(0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 0);
      chk("rst_count",   32'(bus.o_count), 0);
      chk("rst_wr_en",   32'(bus.o_wr_en), 0);
      chk("rst_rd_en",   32'(bus.o_rd_en), 0);
      chk("rst_ovf",     32'(bus.o_overflow), 0);
      chk("rst_unf",     32'(bus.o_underflow), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Fill: 16 writes, no reads.
      for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0);
      chk("fill_wr_addr", 32'(bus.wr_addr), 32'h10);
      chk("fill_rd_addr", 32'(bus.rd_addr), 0);
      chk("fill_count",   32'(bus.o_count), 16);

      // 17th write refused by the local full guard.
      step(1, 0, 0, 1, 0);
      chk("full_wr_addr", 32'(bus.wr_addr), 32'h10);

      // Simultaneous read and write at full.
      step(1, 1, 0, 1, 1);
      chk("rw_full_wr", 32'(bus.wr_addr), 17);
      chk("rw_full_rd", 32'(bus.rd_addr), 1);
      chk("rw_full_cnt", 32'(bus.o_count), 16);

      // Flush, then read at empty (underflow), held, then flush again.
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);

      // 40 write/read pairs through the pointer wrap.
      for (int i = 0; i < 40; i++) begin
         chk("seq_mem_wr_addr", 32'(bus.o_mem_wr_addr), 32'(i % 16));
         step(1, 0, 0, 1, 0);
         chk("seq_cnt_one", 32'(bus.o_count), 1);
         step(0, 1, 0, 1, 1);
         chk("seq_cnt_zero", 32'(bus.o_count), 0);
      end
      chk("seq_wr_wrap", 32'(bus.wr_addr), 40 % 32);

      // Load 5, then flush while a write is requested.
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
      step(1, 0, 1, 1, 0);
      chk("flush_wr_addr", 32'(bus.wr_addr), 0);
      chk("flush_count",   32'(bus.o_count), 0);

      // Load 7, then reset asynchronously mid-cycle.
      for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 1);
      chk("pre_rst_count", 32'(bus.o_count), 7);
      #2;
      drive(0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_wr_addr", 32'(bus.wr_addr), 0);
      chk("arst_rd_addr", 32'(bus.rd_addr), 0);
      chk("arst_count",   32'(bus.o_count), 0);
      chk("arst_wr_en",   32'(bus.o_wr_en), 0);
      chk("arst_rd_en",   32'(bus.o_rd_en), 0);
      chk("arst_ovf",     32'(bus.o_overflow), 0);
      chk("arst_unf",     32'(bus.o_underflow), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("post_rst_mem_wr", 32'(bus.o_mem_wr_addr), 0);
      step(1, 0, 0, 1, 0);
      chk("post_rst_wr_addr", 32'(bus.wr_addr), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
